// File: rtl/point_queue_search_ctrl.sv
// rtl/point_queue_search_ctrl.sv - circular point queue with sequential per-field search
// Optional find-last scanning is built when POINT_QUEUE_SEARCH_FIND_LAST_EN is defined.

module point_queue_search_ctrl #(
    parameter int DEPTH = 8,
    parameter int FW    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    input  logic [3*FW-1:0]            push_data,
    output logic                       push_ready,
    input  logic                       pop_valid,
    output logic                       pop_ready,
    input  logic                       search_valid,
    output logic                       search_ready,
    input  logic [1:0]                 search_field,
`ifdef POINT_QUEUE_SEARCH_FIND_LAST_EN
    input  logic                       search_last,
`endif
    input  logic [FW-1:0]              search_key,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic                       result_found,
    output logic [$clog2(DEPTH)-1:0]   result_index,
    output logic [3*FW-1:0]            result_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int EW = 3 * FW;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [EW-1:0] mem [DEPTH];

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [FW-1:0] key_q, key_d;
    logic [1:0]    field_q, field_d;
    logic          result_found_q, result_found_d;
    logic [AW-1:0] result_index_q, result_index_d;
    logic [EW-1:0] result_data_q, result_data_d;
`ifdef POINT_QUEUE_SEARCH_FIND_LAST_EN
    logic          last_q, last_d;
`endif

    logic          is_idle;
    logic          push_fire, pop_fire, search_fire;
    logic [AW-1:0] rd_ptr;
    logic [EW-1:0] cur_entry;
    logic [FW-1:0] field_val;
    logic          field_hit;
    logic          scan_done;
    logic [AW-1:0] next_idx;

    assign is_idle      = (state_q == ST_IDLE);
    assign push_ready   = is_idle && (count_q != CNT_FULL);
    assign pop_ready    = is_idle && (count_q != '0);
    assign search_ready = is_idle;
    assign push_fire    = push_valid && push_ready;
    assign pop_fire     = pop_valid && pop_ready;
    assign search_fire  = search_valid && search_ready;

    assign result_valid = (state_q == ST_RESP);
    assign result_found = result_found_q;
    assign result_index = result_index_q;
    assign result_data  = result_data_q;
    assign count        = count_q;

    // idx is always relative to head; the pointer add wraps because DEPTH is a power of two
    assign rd_ptr    = head_q + idx_q;
    assign cur_entry = mem[rd_ptr];

    always_comb begin
        field_val = '0;
        case (field_q)
            2'd0:    field_val = cur_entry[EW-1 -: FW];
            2'd1:    field_val = cur_entry[2*FW-1 -: FW];
            2'd2:    field_val = cur_entry[FW-1:0];
            default: field_val = '0;
        endcase
    end

    assign field_hit = (field_q != 2'd3) && (field_val == key_q) && ({1'b0, idx_q} < count_q);

    always_comb begin
`ifdef POINT_QUEUE_SEARCH_FIND_LAST_EN
        if (last_q) begin
            scan_done = (idx_q == '0);
            next_idx  = idx_q - 1'b1;
        end else begin
            scan_done = (({1'b0, idx_q} + 1'b1) >= count_q);
            next_idx  = idx_q + 1'b1;
        end
`else
        scan_done = (({1'b0, idx_q} + 1'b1) >= count_q);
        next_idx  = idx_q + 1'b1;
`endif
    end

    always_comb begin
        state_d        = state_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        idx_d          = idx_q;
        key_d          = key_q;
        field_d        = field_q;
        result_found_d = result_found_q;
        result_index_d = result_index_q;
        result_data_d  = result_data_q;
`ifdef POINT_QUEUE_SEARCH_FIND_LAST_EN
        last_d         = last_q;
`endif

        if (push_fire) begin
            tail_d = tail_q + 1'b1;
        end
        if (pop_fire) begin
            head_d = head_q + 1'b1;
        end
        case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                // The search sees the queue as it stands after this edge's push/pop
                if (search_fire) begin
                    state_d = ST_SCAN;
                    key_d   = search_key;
                    field_d = search_field;
                    idx_d   = '0;
`ifdef POINT_QUEUE_SEARCH_FIND_LAST_EN
                    last_d  = search_last;
                    if (search_last && (count_d != '0)) begin
                        idx_d = AW'(count_d - 1'b1);
                    end
`endif
                end
            end
            ST_SCAN: begin
                if (field_hit) begin
                    state_d        = ST_RESP;
                    result_found_d = 1'b1;
                    result_index_d = idx_q;
                    result_data_d  = cur_entry;
                end else if (scan_done) begin
                    state_d        = ST_RESP;
                    result_found_d = 1'b0;
                    result_index_d = '0;
                    result_data_d  = '0;
                end else begin
                    idx_d = next_idx;
                end
            end
            ST_RESP: begin
                if (result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            idx_q          <= '0;
            key_q          <= '0;
            field_q        <= '0;
            result_found_q <= 1'b0;
            result_index_q <= '0;
            result_data_q  <= '0;
`ifdef POINT_QUEUE_SEARCH_FIND_LAST_EN
            last_q         <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            idx_q          <= idx_d;
            key_q          <= key_d;
            field_q        <= field_d;
            result_found_q <= result_found_d;
            result_index_q <= result_index_d;
            result_data_q  <= result_data_d;
`ifdef POINT_QUEUE_SEARCH_FIND_LAST_EN
            last_q         <= last_d;
`endif
        end
    end

    // Storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (!rst && push_fire) begin
            mem[tail_q] <= push_data;
        end
    end

endmodule

// File: tb/tb_point_queue_search_ctrl.sv
// tb/tb_point_queue_search_ctrl.sv - self-checking bench for point_queue_search_ctrl
// Directed scenarios followed by randomized traffic against a queue-based reference model.

module tb_point_queue_search_ctrl;

    localparam int DEPTH = 8;
    localparam int FW    = 32;
    localparam int EW    = 3 * FW;
    localparam int AW    = $clog2(DEPTH);

    logic            clk;
    logic            rst;
    logic            push_valid;
    logic [EW-1:0]   push_data;
    logic            push_ready;
    logic            pop_valid;
    logic            pop_ready;
    logic            search_valid;
    logic            search_ready;
    logic [1:0]      search_field;
    logic            search_last;
    logic [FW-1:0]   search_key;
    logic            result_valid;
    logic            result_ready;
    logic            result_found;
    logic [AW-1:0]   result_index;
    logic [EW-1:0]   result_data;
    logic [AW:0]     count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [EW-1:0] model_q [$];

    point_queue_search_ctrl #(.DEPTH(DEPTH), .FW(FW)) dut (
        .clk          (clk),
        .rst          (rst),
        .push_valid   (push_valid),
        .push_data    (push_data),
        .push_ready   (push_ready),
        .pop_valid    (pop_valid),
        .pop_ready    (pop_ready),
        .search_valid (search_valid),
        .search_ready (search_ready),
        .search_field (search_field),
`ifdef POINT_QUEUE_SEARCH_FIND_LAST_EN
        .search_last  (search_last),
`endif
        .search_key   (search_key),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_found (result_found),
        .result_index (result_index),
        .result_data  (result_data),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [EW-1:0] mk(input int x, input int y, input int z);
        logic [FW-1:0] fx, fy, fz;
        fx = FW'(x);
        fy = FW'(y);
        fz = FW'(z);
        return {fx, fy, fz};
    endfunction

    function automatic logic [FW-1:0] coord(input logic [EW-1:0] e, input int f);
        if (f == 0) return e[3*FW-1:2*FW];
        if (f == 1) return e[2*FW-1:FW];
        return e[FW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        model_q.delete();
    endtask

    task automatic do_push(input logic [EW-1:0] e);
        bit acc;
        acc = (model_q.size() < DEPTH);
        chk("push_ready", push_ready, acc);
        push_valid = 1'b1;
        push_data  = e;
        step();
        push_valid = 1'b0;
        if (acc) model_q.push_back(e);
        chk("count_after_push", count, model_q.size());
    endtask

    task automatic do_pop();
        bit acc;
        acc = (model_q.size() > 0);
        chk("pop_ready", pop_ready, acc);
        pop_valid = 1'b1;
        step();
        pop_valid = 1'b0;
        if (acc) void'(model_q.pop_front());
        chk("count_after_pop", count, model_q.size());
    endtask

    // Called right after edge A; the model is evaluated on the queue as it stands now.
    task automatic wait_result(input int f, input logic [FW-1:0] key, input bit last, input int hold);
        int n, k, lat, cyc;
        bit found;
        logic [EW-1:0] edata;
        n = model_q.size();
        found = 0;
        k = 0;
        if (f != 3) begin
            if (!last) begin
                for (int i = 0; i < n; i++)
                    if (!found && coord(model_q[i], f) == key) begin found = 1; k = i; end
            end else begin
                for (int i = n - 1; i >= 0; i--)
                    if (!found && coord(model_q[i], f) == key) begin found = 1; k = i; end
            end
        end
        if (found) lat = last ? (n - k) : (k + 1);
        else       lat = (n > 0) ? n : 1;
        edata = found ? model_q[k] : '0;
        if (!found) k = 0;
        cyc = 0;
        while (!result_valid && cyc < 200) begin
            step();
            cyc++;
        end
        chk("resp_latency", cyc, lat);
        chk("result_found", result_found, found);
        chk("result_index", result_index, k);
        chk("result_data", result_data, edata);
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_valid", result_valid, 1'b1);
            chk("hold_data", result_data, edata);
        end
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        chk("resp_released", result_valid, 1'b0);
        chk("ready_after_resp", search_ready, 1'b1);
    endtask

    task automatic do_search(input int f, input logic [FW-1:0] key, input bit last, input int hold);
        chk("search_ready", search_ready, 1'b1);
        search_valid = 1'b1;
        search_field = 2'(f);
        search_key   = key;
        search_last  = last;
        step();
        search_valid = 1'b0;
        wait_result(f, key, last, hold);
    endtask

    initial begin
        int op, f;
        bit lst;
        logic [FW-1:0] key;
        rst = 1'b1;
        push_valid = 1'b0; push_data = '0; pop_valid = 1'b0;
        search_valid = 1'b0; search_field = '0; search_key = '0; search_last = 1'b0;
        result_ready = 1'b0;
        do_reset();

        chk("rst_push_ready", push_ready, 1'b1);
        chk("rst_pop_ready", pop_ready, 1'b0);
        chk("rst_search_ready", search_ready, 1'b1);
        chk("rst_result_valid", result_valid, 1'b0);
        chk("rst_result_found", result_found, 1'b0);
        chk("rst_result_index", result_index, 0);
        chk("rst_result_data", result_data, 0);
        chk("rst_count", count, 0);

        do_push(mk(1, 2, 3));
        do_push(mk(2, 3, 5));
        do_push(mk(1, 4, 5));
        do_search(2, 5, 0, 2);
        do_search(0, 1, 0, 0);
        do_search(1, 9, 0, 1);
        do_search(3, 1, 0, 0);
`ifdef POINT_QUEUE_SEARCH_FIND_LAST_EN
        do_search(0, 1, 1, 0);
        do_search(1, 9, 1, 0);
`endif
        do_pop(); do_pop(); do_pop();
        do_search(0, 0, 0, 0);
        do_pop();

        do_reset();
        for (int i = 0; i < DEPTH; i++) do_push(mk(i, i, 10 + i));
        do_push(mk(99, 99, 99));
        chk("full_count", count, DEPTH);
        do_pop(); do_pop(); do_pop();
        for (int i = 0; i < 3; i++) do_push(mk(20 + i, 20 + i, 30 + i));
        do_search(2, 32, 0, 0);
        do_search(0, 3, 0, 0);
        do_search(0, 20, 0, 0);

        // push, pop and search together: search must see the post-update queue
        do_pop();
        chk("combo_push_ready", push_ready, 1'b1);
        chk("combo_pop_ready", pop_ready, 1'b1);
        push_valid = 1'b1; push_data = mk(7, 7, 77);
        pop_valid = 1'b1;
        search_valid = 1'b1; search_field = 2'd2; search_key = 77; search_last = 1'b0;
        step();
        push_valid = 1'b0; pop_valid = 1'b0; search_valid = 1'b0;
        void'(model_q.pop_front());
        model_q.push_back(mk(7, 7, 77));
        wait_result(2, 77, 0, 0);
        chk("combo_count", count, model_q.size());

        do_reset();
        for (int i = 0; i < 5; i++) do_push(mk(i, i, i));
        search_valid = 1'b1; search_field = 2'd1; search_key = 99; search_last = 1'b0;
        step();
        search_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_q.delete();
        chk("midscan_rst_valid", result_valid, 1'b0);
        chk("midscan_rst_count", count, 0);
        chk("midscan_rst_search_ready", search_ready, 1'b1);
        chk("midscan_rst_pop_ready", pop_ready, 1'b0);
        step();
        chk("midscan_rst_stays_idle", result_valid, 1'b0);

`ifdef POINT_QUEUE_SEARCH_FIND_LAST_EN
        do_push(mk(1, 2, 3));
        do_push(mk(2, 3, 5));
        do_push(mk(1, 4, 5));
        do_search(0, 1, 1, 0);
        do_reset();
`endif

        for (int it = 0; it < 150; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                do_push(mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)));
            end else if (op <= 5) begin
                do_pop();
            end else if (op <= 8) begin
                f = $urandom_range(0, 3);
                if (model_q.size() > 0 && $urandom_range(0, 1) == 1 && f != 3)
                    key = coord(model_q[$urandom_range(0, model_q.size() - 1)], f);
                else
                    key = FW'($urandom_range(0, 4));
`ifdef POINT_QUEUE_SEARCH_FIND_LAST_EN
                lst = 1'($urandom_range(0, 1));
`else
                lst = 1'b0;
`endif
                do_search(f, key, lst, $urandom_range(0, 2));
            end else if (model_q.size() > 0 && model_q.size() < DEPTH) begin
                push_valid = 1'b1;
                push_data  = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                pop_valid  = 1'b1;
                step();
                push_valid = 1'b0;
                pop_valid  = 1'b0;
                void'(model_q.pop_front());
                model_q.push_back(push_data);
                chk("pushpop_count", count, model_q.size());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
